ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 103 ++++++++++
 tb/tb_ram_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Shares one single-port data RAM between the CPU and a host/debug port.
// The CPU owns the RAM by default; a waiting host gets bounded-latency bursts.
module ram_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int BURST_MAX    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [14:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [14:0] host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_gnt,
    output logic        host_rvalid,
    output logic [15:0] host_rdata,
    output logic [14:0] ram_address,
    output logic [15:0] ram_in,
    output logic        ram_load,
    input  logic [15:0] ram_out
);

    typedef enum logic {
        CPU_OWN  = 1'b0,
        HOST_OWN = 1'b1
    } state_t;

    localparam logic [7:0] STARVE_SAT = 8'(STARVE_LIMIT);
    localparam logic [7:0] BURST_SAT  = 8'(BURST_MAX);
    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  r_burst_cnt;
    logic        r_host_rvalid;
    logic [15:0] r_host_rdata;

    logic w_host_own;
    logic w_host_gnt;
    logic w_host_read;
    logic w_to_host;
    logic w_to_cpu;

    assign w_host_own  = (r_state == HOST_OWN);
    // Reset masks every side effect, whatever state the FSM is in.
    assign w_host_gnt  = ~reset & w_host_own & host_req;
    assign w_host_read = w_host_gnt & ~host_we;

    assign w_to_host = ~w_host_own & host_req & (~cpu_req | (r_wait_cnt >= STARVE_SAT));
    assign w_to_cpu  = w_host_own & (~host_req | (cpu_req & (r_burst_cnt >= BURST_LAST)));

    always_comb begin
        ram_address = w_host_own ? host_addr  : cpu_addr;
        ram_in      = w_host_own ? host_wdata : cpu_wdata;
        ram_load    = ~reset & (w_host_own ? (host_req & host_we) : (cpu_req & cpu_write));
        cpu_rdata   = w_host_own ? 16'h0000 : ram_out;
        cpu_stall   = ~reset & w_host_own & cpu_req;
    end

    assign host_gnt    = w_host_gnt;
    assign host_rvalid = r_host_rvalid;
    assign host_rdata  = r_host_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= CPU_OWN;
            r_wait_cnt    <= 8'd0;
            r_burst_cnt   <= 8'd0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= 16'h0000;
        end else begin
            r_host_rvalid <= w_host_read;
            if (w_host_read) begin
                r_host_rdata <= ram_out;
            end
            if (!w_host_own) begin
                if (w_to_host) begin
                    r_state     <= HOST_OWN;
                    r_wait_cnt  <= 8'd0;
                    r_burst_cnt <= 8'd0;
                end else if (!host_req) begin
                    r_wait_cnt <= 8'd0;
                end else if (r_wait_cnt < STARVE_SAT) begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
            end else begin
                // wait_cnt stays at zero here, so the CPU always gets a full window back.
                if (r_burst_cnt < BURST_SAT) begin
                    r_burst_cnt <= r_burst_cnt + 8'd1;
                end
                if (w_to_cpu) begin
                    r_state <= CPU_OWN;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model and a reference memory.
module tb_ram_arbiter;

    localparam int STARVE_LIMIT = 8;
    localparam int BURST_MAX    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_write;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        host_req, host_we;
    logic [14:0] host_addr;
    logic [15:0] host_wdata;
    logic        host_gnt, host_rvalid;
    logic [15:0] host_rdata;
    logic [14:0] ram_address;
    logic [15:0] ram_in, ram_out;
    logic        ram_load;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .ram_address(ram_address), .ram_in(ram_in),
        .ram_load(ram_load), .ram_out(ram_out)
    );

    // Data RAM: combinational read, write on rising edge.
    logic [15:0] mem [0:32767];
    assign ram_out = mem[ram_address];
    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; cpu_req = 1; cpu_write = 1; host_req = 1; host_we = 1; host_addr = 15'h50;
        #2;
        checks++; if (ram_load !== 1'b0) begin errors++; $display("FAIL reset_ram_load got=%b exp=0", ram_load); end
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL reset_host_gnt got=%b exp=0", host_gnt); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall got=%b exp=0", cpu_stall); end
        tick();
        reset = 0; host_req = 0; host_we = 0; cpu_write = 0;
        #2;
        checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", host_rvalid); end
        checks++; if (host_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", host_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_post_stall got=%b exp=0", cpu_stall); end
        tick();
        $display("test_reset done");
    endtask

    task automatic test_idle();
        idle_inputs();
        cpu_req = 1; cpu_write = 1; cpu_addr = 15'h0010; cpu_wdata = 16'h1234;
        #2;
        checks++; if (ram_load !== 1'b1) begin errors++; $display("FAIL idle_load got=%b exp=1", ram_load); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL idle_stall got=%b exp=0", cpu_stall); end
        checks++; if (ram_address !== 15'h0010 || ram_in !== 16'h1234) begin errors++;
            $display("FAIL idle_port got=%h/%h exp=0010/1234", ram_address, ram_in); end
        tick();
        cpu_write = 0;
        #2;
        checks++; if (cpu_rdata !== 16'h1234) begin errors++; $display("FAIL idle_readback got=%h exp=1234", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL idle_stall2 got=%b exp=0", cpu_stall); end
        tick();
        $display("test_idle done");
    endtask

    task automatic test_host_only();
        do_reset();
        host_req = 1; host_we = 1; host_addr = 15'h0100; host_wdata = 16'hBEEF;
        #2;
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL host_entry_gnt got=%b exp=0", host_gnt); end
        tick(); #2;
        checks++; if (host_gnt !== 1'b1 || ram_load !== 1'b1) begin errors++;
            $display("FAIL host_write got gnt=%b load=%b exp 1/1", host_gnt, ram_load); end
        tick();
        host_we = 0;
        #2;
        checks++; if (host_gnt !== 1'b1 || ram_load !== 1'b0) begin errors++;
            $display("FAIL host_read got gnt=%b load=%b exp 1/0", host_gnt, ram_load); end
        checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL host_write_rvalid got=%b exp=0", host_rvalid); end
        tick();
        host_req = 0;
        #2;
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== 16'hBEEF) begin errors++;
            $display("FAIL host_rdata got v=%b d=%h exp 1/beef", host_rvalid, host_rdata); end
        tick(); #2;
        checks++; if (host_rvalid !== 1'b0 || host_rdata !== 16'hBEEF) begin errors++;
            $display("FAIL host_rdata_hold got v=%b d=%h exp 0/beef", host_rvalid, host_rdata); end
        tick();
        $display("test_host_only done");
    endtask

    task automatic test_starvation();
        int first = -1;
        do_reset();
        cpu_req = 1; cpu_addr = 15'h0010; host_req = 1; host_addr = 15'h0100;
        for (int c = 0; c < 30; c++) begin
            #2;
            if (host_gnt === 1'b1 && first < 0) first = c;
            checks++; if (cpu_stall !== host_gnt) begin errors++;
                $display("FAIL starve_stall cycle=%0d got stall=%b exp=%b", c, cpu_stall, host_gnt); end
            tick();
        end
        checks++; if (first != STARVE_LIMIT + 1) begin errors++;
            $display("FAIL starve_first_grant got=%0d exp=%0d", first, STARVE_LIMIT + 1); end
        $display("test_starvation first grant at cycle %0d", first);
    endtask

    task automatic test_burst();
        logic exp_g;
        do_reset();
        cpu_req = 1; cpu_write = 1; cpu_addr = 15'h0030; host_req = 1; host_addr = 15'h0100;
        for (int c = 0; c < 48; c++) begin
            cpu_wdata = 16'($urandom);
            exp_g = (c >= STARVE_LIMIT + 1) &&
                    (((c - (STARVE_LIMIT + 1)) % (BURST_MAX + STARVE_LIMIT + 1)) < BURST_MAX);
            #2;
            checks++; if (host_gnt !== exp_g || cpu_stall !== exp_g || ram_load !== !exp_g) begin errors++;
                $display("FAIL burst cycle=%0d got gnt=%b stall=%b load=%b exp gnt=stall=%b", c, host_gnt, cpu_stall, ram_load, exp_g); end
            tick();
        end
        $display("test_burst done");
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        host_req = 1; host_addr = 15'h0100;
        tick(); #2;
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL midrst_first_gnt got=%b exp=1", host_gnt); end
        tick();
        reset = 1;
        #2;
        checks++; if (ram_load !== 1'b0 || host_gnt !== 1'b0) begin errors++;
            $display("FAIL midrst_cycle got load=%b gnt=%b exp 0/0", ram_load, host_gnt); end
        tick();
        reset = 0; cpu_req = 1;
        #2;
        checks++; if (host_rvalid !== 1'b0 || host_rdata !== 16'h0) begin errors++;
            $display("FAIL midrst_rvalid got v=%b d=%h exp 0/0000", host_rvalid, host_rdata); end
        checks++; if (cpu_stall !== 1'b0 || host_gnt !== 1'b0) begin errors++;
            $display("FAIL midrst_state got stall=%b gnt=%b exp 0/0", cpu_stall, host_gnt); end
        tick();
        $display("test_reset_mid_burst done");
    endtask

    task automatic test_handover();
        do_reset();
        host_req = 1; host_we = 1; host_addr = 15'h0200; host_wdata = 16'h5A5A;
        tick(); #2;
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL hand_gnt got=%b exp=1", host_gnt); end
        tick();
        host_req = 0; host_we = 0; cpu_req = 1; cpu_write = 1; cpu_addr = 15'h0020; cpu_wdata = 16'hC0DE;
        #2;
        checks++; if (cpu_stall !== 1'b1 || ram_load !== 1'b0) begin errors++;
            $display("FAIL hand_stall got stall=%b load=%b exp 1/0", cpu_stall, ram_load); end
        tick(); #2;
        checks++; if (cpu_stall !== 1'b0 || ram_load !== 1'b1) begin errors++;
            $display("FAIL hand_serve got stall=%b load=%b exp 0/1", cpu_stall, ram_load); end
        tick();
        cpu_write = 0;
        #2;
        checks++; if (cpu_rdata !== 16'hC0DE) begin errors++; $display("FAIL hand_readback got=%h exp=c0de", cpu_rdata); end
        tick();
        $display("test_handover done");
    endtask

    // Model: who owns the RAM, how long the host has been pending, how many host cycles in the current burst.
    task automatic test_random();
        logic        host_owns = 0;
        int          waited = 0;
        int          burst_cycles = 0;
        logic        m_rvalid = 0;
        logic [15:0] m_rdata = '0;
        logic [15:0] ref_mem [8];
        logic        e_load, e_gnt, e_stall;
        logic [14:0] e_addr;
        logic [15:0] e_in, e_rdata;
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 59) == 0);
            cpu_req    = ($urandom_range(0, 9) < 7);
            cpu_write  = ($urandom_range(0, 1) == 1);
            cpu_addr   = 15'h7000 + 15'($urandom_range(0, 7));
            cpu_wdata  = 16'($urandom);
            host_req   = ($urandom_range(0, 9) < 6);
            host_we    = ($urandom_range(0, 1) == 1);
            host_addr  = 15'h7000 + 15'($urandom_range(0, 7));
            host_wdata = 16'($urandom);
            e_addr  = host_owns ? host_addr : cpu_addr;
            e_in    = host_owns ? host_wdata : cpu_wdata;
            e_load  = !reset && (host_owns ? (host_req && host_we) : (cpu_req && cpu_write));
            e_gnt   = !reset && host_owns && host_req;
            e_stall = !reset && host_owns && cpu_req;
            e_rdata = host_owns ? 16'h0 : ref_mem[cpu_addr[2:0]];
            #2;
            checks++; if (ram_load !== e_load || host_gnt !== e_gnt || cpu_stall !== e_stall) begin errors++;
                $display("FAIL rand_ctrl n=%0d got load=%b gnt=%b stall=%b exp %b/%b/%b", n, ram_load, host_gnt, cpu_stall, e_load, e_gnt, e_stall); end
            checks++; if (host_rvalid !== m_rvalid || host_rdata !== m_rdata) begin errors++;
                $display("FAIL rand_hostrd n=%0d got v=%b d=%h exp %b/%h", n, host_rvalid, host_rdata, m_rvalid, m_rdata); end
            if (!reset) begin
                checks++; if (cpu_rdata !== e_rdata) begin errors++;
                    $display("FAIL rand_cpurd n=%0d got=%h exp=%h", n, cpu_rdata, e_rdata); end
            end
            if (e_load) begin
                checks++; if (ram_address !== e_addr || ram_in !== e_in) begin errors++;
                    $display("FAIL rand_wport n=%0d got %h/%h exp %h/%h", n, ram_address, ram_in, e_addr, e_in); end
            end
            if (reset) begin
                host_owns = 0; waited = 0; burst_cycles = 0; m_rvalid = 0; m_rdata = '0;
            end else begin
                m_rvalid = e_gnt && !host_we;
                if (m_rvalid) m_rdata = ref_mem[host_addr[2:0]];
                if (e_load) ref_mem[e_addr[2:0]] = e_in;
                if (!host_owns) begin
                    if (host_req && (!cpu_req || waited >= STARVE_LIMIT)) begin
                        host_owns = 1; waited = 0; burst_cycles = 0;
                    end else begin
                        waited = host_req ? waited + 1 : 0;
                    end
                end else begin
                    burst_cycles++;
                    if (!host_req || (cpu_req && burst_cycles >= BURST_MAX)) host_owns = 0;
                end
            end
            tick();
        end
        reset = 0;
        $display("test_random done, 600 cycles");
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = '0;
        test_reset();
        test_idle();
        test_host_only();
        test_starvation();
        test_burst();
        test_reset_mid_burst();
        test_handover();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
